led_scan_driver: RTL and testbench

//   Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits. It

---
 rtl/led_scan_driver.sv | 140 ++++++++++++++
 tb/tb_led_scan_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with a double-buffered
// character store, per-digit blink and inter-digit ghost blanking.
module led_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned GUARD        = 2,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_idx,
  input  logic [3:0]                    wr_char,
  input  logic                          commit,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  output logic                          commit_pending,
  output logic                          frame_tick,
  output logic [6:0]                    led,
  output logic [NUM_DIGITS-1:0]         an
);

  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam int unsigned PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0]   PMax   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]   PGuard = PW'(GUARD);
  localparam logic [IdxW-1:0] DMax   = IdxW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0]   BMax   = BW'(BLINK_FRAMES - 1);
  localparam logic [3:0]      CharSpace = 4'd12;

  function automatic logic [6:0] decode(input logic [3:0] c);
    case (c)
      4'd0:    decode = 7'b0000001;
      4'd1:    decode = 7'b1001111;
      4'd2:    decode = 7'b0010010;
      4'd3:    decode = 7'b0000110;
      4'd4:    decode = 7'b1001100;
      4'd5:    decode = 7'b0100100;
      4'd6:    decode = 7'b1100000;
      4'd7:    decode = 7'b0001111;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0001100;
      4'd10:   decode = 7'b1111110;
      4'd11:   decode = 7'b0111000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  logic [PW-1:0]         p_q, p_d;
  logic [IdxW-1:0]       d_q, d_d;
  logic [BW-1:0]         blink_q, blink_d;
  logic                  phase_q, phase_d;
  logic                  pend_q, pend_d;
  logic                  ft_q, ft_d;
  logic [6:0]            led_q, led_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            shadow_q [NUM_DIGITS];
  logic [3:0]            shadow_d [NUM_DIGITS];
  logic [3:0]            active_q [NUM_DIGITS];
  logic [3:0]            active_d [NUM_DIGITS];
  logic                  slot_end, frame_end;

  always_comb begin
    slot_end  = (p_q == PMax);
    frame_end = slot_end && (d_q == DMax);

    p_d = slot_end ? '0 : p_q + PW'(1);
    d_d = d_q;
    if (slot_end) d_d = (d_q == DMax) ? '0 : d_q + IdxW'(1);

    blink_d = blink_q;
    phase_d = phase_q;
    if (frame_end) begin
      if (blink_q == BMax) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + BW'(1);
      end
    end

    // Copy takes the pre-write shadow; a same-cycle write lands in shadow only.
    active_d = active_q;
    pend_d   = pend_q;
    if (frame_end && pend_q) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end else if (commit) begin
      pend_d = 1'b1;
    end

    shadow_d = shadow_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (wr_en && (wr_idx == IdxW'(i))) shadow_d[i] = wr_char;
    end

    an_d  = '1;
    led_d = 7'h7F;
    if (p_q >= PGuard) begin
      an_d[d_q] = 1'b0;
      if (!(blink_mask[d_q] && phase_q)) led_d = decode(active_q[d_q]);
    end

    ft_d = frame_end;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q     <= '0;
      d_q     <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      pend_q  <= 1'b0;
      ft_q    <= 1'b0;
      led_q   <= 7'h7F;
      an_q    <= '1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= CharSpace;
        active_q[i] <= CharSpace;
      end
    end else begin
      p_q      <= p_d;
      d_q      <= d_d;
      blink_q  <= blink_d;
      phase_q  <= phase_d;
      pend_q   <= pend_d;
      ft_q     <= ft_d;
      led_q    <= led_d;
      an_q     <= an_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign commit_pending = pend_q;
  assign frame_tick     = ft_q;
  assign led            = led_q;
  assign an             = an_q;

endmodule

// File: tb/tb_led_scan_driver.sv
// Scoreboard bench for led_scan_driver: a time-based reference model predicts
// every registered output cycle; a monitor pops and compares.
module tb_led_scan_driver;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int GD = 2;
  localparam int BF = 2;
  localparam int FR = ND * SD;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_idx = '0;
  logic [3:0]    wr_char = '0;
  logic          commit = 1'b0;
  logic [ND-1:0] blink_mask = '0;
  logic          commit_pending, frame_tick;
  logic [6:0]    led;
  logic [ND-1:0] an;

  int checks = 0;
  int errors = 0;

  led_scan_driver #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .GUARD       (GD),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_idx        (wr_idx),
    .wr_char       (wr_char),
    .commit        (commit),
    .blink_mask    (blink_mask),
    .commit_pending(commit_pending),
    .frame_tick    (frame_tick),
    .led           (led),
    .an            (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] led;
    logic       ft;
    logic       cp;
  } exp_t;

  exp_t q[$];

  logic [6:0] seg_tab [16];
  int         m_t;
  bit         m_pend;
  logic [3:0] m_shadow [ND];
  logic [3:0] m_active [ND];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
    end
  endtask

  initial begin
    seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111; seg_tab[2]  = 7'b0010010;
    seg_tab[3]  = 7'b0000110; seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
    seg_tab[6]  = 7'b1100000; seg_tab[7]  = 7'b0001111; seg_tab[8]  = 7'b0000000;
    seg_tab[9]  = 7'b0001100; seg_tab[10] = 7'b1111110; seg_tab[11] = 7'b0111000;
    for (int i = 12; i < 16; i++) seg_tab[i] = 7'b1111111;
  end

  // Reference model: scan position, frame count and blink phase derived from
  // elapsed cycles since reset; text buffers updated by the commit rules.
  always @(posedge clk) begin
    exp_t e;
    int   p, d, ph;
    bit   bnd;
    if (reset) begin
      m_t    = 0;
      m_pend = 0;
      for (int i = 0; i < ND; i++) begin
        m_shadow[i] = 4'd12;
        m_active[i] = 4'd12;
      end
      e = '{an: 4'hF, led: 7'h7F, ft: 1'b0, cp: 1'b0};
      q.push_back(e);
    end else begin
      p   = m_t % SD;
      d   = (m_t / SD) % ND;
      bnd = (m_t % FR) == FR - 1;
      ph  = ((m_t / FR) / BF) % 2;
      if (p < GD) begin
        e.an  = 4'hF;
        e.led = 7'h7F;
      end else begin
        e.an  = ~(4'b0001 << d);
        e.led = (blink_mask[d] && ph == 1) ? 7'h7F : seg_tab[m_active[d]];
      end
      e.ft = bnd;
      if (bnd && m_pend) begin
        for (int i = 0; i < ND; i++) m_active[i] = m_shadow[i];
        m_pend = 0;
      end else if (commit) begin
        m_pend = 1;
      end
      if (wr_en && int'(wr_idx) < ND) m_shadow[wr_idx] = wr_char;
      e.cp = m_pend;
      q.push_back(e);
      m_t++;
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("an", 32'(an), 32'(e.an));
      chk("led", 32'(led), 32'(e.led));
      chk("frame_tick", 32'(frame_tick), 32'(e.ft));
      chk("commit_pending", 32'(commit_pending), 32'(e.cp));
      chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int idx, input int ch);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_idx  = 2'(idx);
    wr_char = 4'(ch);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic pulse_commit();
    @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  initial begin
    idle(3);
    reset = 1'b0;

    // Blank free-run: frame ticks and guard/slot pattern from the model.
    idle(70);

    // Shadow writes stay invisible until commit reaches a frame boundary.
    for (int i = 0; i < ND; i++) wr(i, i + 1);
    idle(40);
    pulse_commit();
    idle(80);

    // Write and commit together in a boundary cycle.
    @(negedge clk);
    while ((m_t % FR) != FR - 1) @(negedge clk);
    wr_en   = 1'b1;
    wr_idx  = 2'd0;
    wr_char = 4'd8;
    commit  = 1'b1;
    @(negedge clk);
    wr_en  = 1'b0;
    commit = 1'b0;
    idle(80);

    // Blink digit 0 showing F.
    blink_mask = 4'b0001;
    wr(0, 11);
    pulse_commit();
    idle(6 * FR);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_idx  = 2'($urandom_range(0, 3));
      wr_char = 4'($urandom_range(0, 15));
      commit  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) blink_mask = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    wr_en  = 1'b0;
    commit = 1'b0;
    blink_mask = 4'b0000;
    idle(2 * FR);

    // Reset mid-slot with a commit pending; writes during reset are lost.
    wr(1, 8);
    @(negedge clk);
    while ((m_t % SD) != 4 || (m_t % FR) > FR - 8) @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    idle(1);
    chk("t6_pending_before", 32'(commit_pending), 32'd1);
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_idx  = 2'd1;
    wr_char = 4'd8;
    #1;
    chk("t6_an_async", 32'(an), 32'hF);
    chk("t6_led_async", 32'(led), 32'h7F);
    chk("t6_pend_async", 32'(commit_pending), 32'd0);
    idle(2);
    wr_en = 1'b0;
    reset = 1'b0;
    idle(10);
    pulse_commit();
    idle(3 * FR);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
